// File: rtl/clock_mode_controller.sv
// clock_mode_controller
// Mode sequencer for a digital alarm clock. It walks the run and set states
// from the five buttons, issues single-cycle adjust pulses to the hour/minute
// counters, gates the seconds counter, and owns the alarm (arm, trigger,
// timeout).
// Optional feature: define ALARM_SNOOZE_EN to enable snooze on btn_d while
// ringing.
module clock_mode_controller #(
  parameter int ALARM_TIMEOUT = 60,
  parameter int SNOOZE_SEC    = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_c,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       tick_1hz,
  input  logic [4:0] clk_hr,
  input  logic [5:0] clk_min,
  input  logic [5:0] clk_sec,
  input  logic [4:0] alm_hr,
  input  logic [5:0] alm_min,
  output logic       sec_en,
  output logic       clk_hr_up,
  output logic       clk_hr_dn,
  output logic       clk_min_up,
  output logic       clk_min_dn,
  output logic       alm_hr_up,
  output logic       alm_hr_dn,
  output logic       alm_min_up,
  output logic       alm_min_dn,
  output logic [2:0] mode,
  output logic       show_alarm,
  output logic       blink,
  output logic       alarm_armed,
  output logic       alarm_active
);

  // state        | meaning
  // RUN          | clock running, alarm may ring
  // SET_CLK_HR   | adjusting clock hours
  // SET_CLK_MIN  | adjusting clock minutes
  // SET_ALM_HR   | adjusting alarm hours
  // SET_ALM_MIN  | adjusting alarm minutes
  typedef enum logic [2:0] {
    RUN         = 3'd0,
    SET_CLK_HR  = 3'd1,
    SET_CLK_MIN = 3'd2,
    SET_ALM_HR  = 3'd3,
    SET_ALM_MIN = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(ALARM_TIMEOUT);

  if (ALARM_TIMEOUT < 1 || ALARM_TIMEOUT > 255) begin : g_bad_alarm_timeout
    $error("ALARM_TIMEOUT must be in 1..255");
  end
  if (SNOOZE_SEC < 1 || SNOOZE_SEC > 1023) begin : g_bad_snooze_sec
    $error("SNOOZE_SEC must be in 1..1023");
  end

  state_t     state;
  state_t     state_next;
  logic       act_c, act_r, act_l, act_u, act_d;
  logic [7:0] adj_next;
  logic [7:0] adj_q;
  logic       in_run;
  logic       match_cond;
  logic       match_hold;
  logic       trigger;
  logic [7:0] ring_cnt;
  logic [7:0] ring_inc;
  logic [7:0] ring_next;
  logic       armed_next;
  logic       active_next;
`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC);
  logic [9:0] snooze_cnt;
  logic [9:0] snooze_next;
`endif

  // Only the highest-priority pressed button acts (c > r > l > u > d).
  always_comb begin
    act_c = btn_c;
    act_r = btn_r & ~btn_c;
    act_l = btn_l & ~btn_c & ~btn_r;
    act_u = btn_u & ~btn_c & ~btn_r & ~btn_l;
    act_d = btn_d & ~btn_c & ~btn_r & ~btn_l & ~btn_u;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state: centre enters/leaves setting, right/left rotate the field.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (act_c && !alarm_active) state_next = SET_CLK_HR;
      end
      SET_CLK_HR: begin
        if (act_c)      state_next = RUN;
        else if (act_r) state_next = SET_CLK_MIN;
        else if (act_l) state_next = SET_ALM_MIN;
      end
      SET_CLK_MIN: begin
        if (act_c)      state_next = RUN;
        else if (act_r) state_next = SET_ALM_HR;
        else if (act_l) state_next = SET_CLK_HR;
      end
      SET_ALM_HR: begin
        if (act_c)      state_next = RUN;
        else if (act_r) state_next = SET_ALM_MIN;
        else if (act_l) state_next = SET_CLK_MIN;
      end
      SET_ALM_MIN: begin
        if (act_c)      state_next = RUN;
        else if (act_r) state_next = SET_CLK_HR;
        else if (act_l) state_next = SET_ALM_HR;
      end
      default: state_next = RUN;
    endcase
  end

  // Route up/down to the field being set; act_u/act_d are exclusive, so at
  // most one bit is ever high. Order: chu chd cmu cmd ahu ahd amu amd.
  always_comb begin
    adj_next = 8'b0;
    case (state)
      SET_CLK_HR:  adj_next = {act_u, act_d, 6'b0};
      SET_CLK_MIN: adj_next = {2'b0, act_u, act_d, 4'b0};
      SET_ALM_HR:  adj_next = {4'b0, act_u, act_d, 2'b0};
      SET_ALM_MIN: adj_next = {6'b0, act_u, act_d};
      default:     adj_next = 8'b0;
    endcase
  end

  // Registered adjust pulses, seconds enable and field blink.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adj_q  <= 8'b0;
      sec_en <= 1'b0;
      blink  <= 1'b0;
    end else begin
      adj_q  <= adj_next;
      sec_en <= tick_1hz && (state_next == RUN);
      if (state_next == RUN)        blink <= 1'b0;
      else if (state_next != state) blink <= 1'b1;
      else if (tick_1hz)            blink <= ~blink;
    end
  end

  assign {clk_hr_up, clk_hr_dn, clk_min_up, clk_min_dn,
          alm_hr_up, alm_hr_dn, alm_min_up, alm_min_dn} = adj_q;
  assign mode       = state;
  assign show_alarm = (state == SET_ALM_HR) || (state == SET_ALM_MIN);

  assign in_run     = (state == RUN);
  assign match_cond = in_run && alarm_armed && (clk_hr == alm_hr) &&
                      (clk_min == alm_min) && (clk_sec == 6'd0);
  // Edge of the match only, so a cleared alarm stays quiet while the time
  // still matches.
  assign trigger    = match_cond && !match_hold && !alarm_active;
  assign ring_inc   = ring_cnt + 8'd1;

  // Alarm next-state; button actions override timers and the trigger.
  always_comb begin
    armed_next  = alarm_armed;
    active_next = alarm_active;
    ring_next   = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snooze_next = snooze_cnt;
`endif
    if (alarm_active && tick_1hz) begin
      if (ring_inc == TIMEOUT) begin
        active_next = 1'b0;
        ring_next   = 8'd0;
      end else begin
        ring_next = ring_inc;
      end
    end
`ifdef ALARM_SNOOZE_EN
    if (snooze_cnt != 10'd0 && tick_1hz) begin
      snooze_next = snooze_cnt - 10'd1;
      if (snooze_cnt == 10'd1 && alarm_armed) begin
        active_next = 1'b1;
        ring_next   = 8'd0;
      end
    end
`endif
    if (trigger) begin
      active_next = 1'b1;
      ring_next   = 8'd0;
    end
    if (in_run && act_u) begin
      armed_next = ~alarm_armed;
      if (alarm_armed) begin
        active_next = 1'b0;
        ring_next   = 8'd0;
`ifdef ALARM_SNOOZE_EN
        snooze_next = 10'd0;
`endif
      end
    end else if (in_run && act_c && alarm_active) begin
      active_next = 1'b0;
      ring_next   = 8'd0;
    end
`ifdef ALARM_SNOOZE_EN
    else if (in_run && act_d && alarm_active) begin
      active_next = 1'b0;
      ring_next   = 8'd0;
      snooze_next = SNOOZE_LOAD;
    end
`endif
  end

  // Alarm registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_armed  <= 1'b0;
      alarm_active <= 1'b0;
      ring_cnt     <= 8'd0;
      match_hold   <= 1'b0;
    end else begin
      alarm_armed  <= armed_next;
      alarm_active <= active_next;
      ring_cnt     <= ring_next;
      match_hold   <= match_cond;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze countdown register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) snooze_cnt <= 10'd0;
    else       snooze_cnt <= snooze_next;
  end
`endif

endmodule

// File: tb/tb_clock_mode_controller.sv
// Self-checking bench for clock_mode_controller. Expected outputs are pushed
// to a scoreboard as each cycle's stimulus is driven and popped once the DUT
// has updated. Snooze expectations follow ALARM_SNOOZE_EN.
module tb_clock_mode_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [4:0] clk_hr = 5'd1;
  logic [5:0] clk_min = 6'd0;
  logic [5:0] clk_sec = 6'd5;
  logic [4:0] alm_hr = 5'd7;
  logic [5:0] alm_min = 6'd30;
  logic       sec_en;
  logic       clk_hr_up, clk_hr_dn, clk_min_up, clk_min_dn;
  logic       alm_hr_up, alm_hr_dn, alm_min_up, alm_min_dn;
  logic [2:0] mode;
  logic       show_alarm, blink, alarm_armed, alarm_active;

  int errors = 0;
  int checks = 0;

  clock_mode_controller #(.ALARM_TIMEOUT(60), .SNOOZE_SEC(3)) dut (
    .clk(clk), .reset(reset),
    .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .tick_1hz(tick_1hz),
    .clk_hr(clk_hr), .clk_min(clk_min), .clk_sec(clk_sec),
    .alm_hr(alm_hr), .alm_min(alm_min),
    .sec_en(sec_en),
    .clk_hr_up(clk_hr_up), .clk_hr_dn(clk_hr_dn),
    .clk_min_up(clk_min_up), .clk_min_dn(clk_min_dn),
    .alm_hr_up(alm_hr_up), .alm_hr_dn(alm_hr_dn),
    .alm_min_up(alm_min_up), .alm_min_dn(alm_min_dn),
    .mode(mode), .show_alarm(show_alarm), .blink(blink),
    .alarm_armed(alarm_armed), .alarm_active(alarm_active)
  );

  always #5 clk = ~clk;

  // outs = {mode, chu,chd,cmu,cmd,ahu,ahd,amu,amd, sec_en,show,blink,armed,active}
  logic [15:0] outs;
  assign outs = {mode, clk_hr_up, clk_hr_dn, clk_min_up, clk_min_dn,
                 alm_hr_up, alm_hr_dn, alm_min_up, alm_min_dn,
                 sec_en, show_alarm, blink, alarm_armed, alarm_active};

  localparam logic [4:0] B_0 = 5'b00000;  // {c, r, l, u, d}
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  localparam logic [7:0] A_NO  = 8'b0000_0000;
  localparam logic [7:0] A_CHU = 8'b1000_0000;
  localparam logic [7:0] A_CHD = 8'b0100_0000;
  localparam logic [7:0] A_CMU = 8'b0010_0000;
  localparam logic [7:0] A_CMD = 8'b0001_0000;
  localparam logic [7:0] A_AHU = 8'b0000_1000;
  localparam logic [7:0] A_AHD = 8'b0000_0100;
  localparam logic [7:0] A_AMU = 8'b0000_0010;
  localparam logic [7:0] A_AMD = 8'b0000_0001;

  // {hr, min, sec}; alarm is fixed at 07:30
  localparam logic [16:0] T_OFF   = {5'd1, 6'd0,  6'd5};
  localparam logic [16:0] T_MATCH = {5'd7, 6'd30, 6'd0};
  localparam logic [16:0] T_NEAR  = {5'd7, 6'd30, 6'd1};

  typedef struct {
    logic [15:0] v;
    string       name;
  } exp_t;

  typedef struct {
    logic [4:0]  b;
    logic        tk;
    logic [16:0] tm;
    logic [15:0] v;
    string       name;
  } step_t;

  exp_t sb[$];

  // flags = {sec_en, show_alarm, blink, alarm_armed, alarm_active}
  function automatic logic [15:0] mk(input logic [2:0] m, input logic [7:0] a,
                                     input logic [4:0] flags);
    return {m, a, flags};
  endfunction

  task automatic drive(input logic [4:0] b, input logic tk, input logic [16:0] tm);
    @(negedge clk);
    {btn_c, btn_r, btn_l, btn_u, btn_d} = b;
    tick_1hz = tk;
    {clk_hr, clk_min, clk_sec} = tm;
    @(posedge clk);
    #1;
    {btn_c, btn_r, btn_l, btn_u, btn_d} = 5'b0;
    tick_1hz = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{mk(3'd0, A_NO, 5'b00000), "held in reset"});
      drive(B_C | B_U, 1'b1, T_MATCH);
      e = sb.pop_front();
      checks++;
      if (outs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{mk(3'd0, A_NO, 5'b00000), "idle after reset"});
    drive(B_0, 1'b0, T_OFF);
    e = sb.pop_front();
    checks++;
    if (outs !== e.v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
    end
  endtask

  task automatic test_run_tick();
    step_t st[$];
    exp_t  e;
    st.push_back('{B_0, 1'b1, T_OFF, mk(3'd0, A_NO, 5'b10000), "sec_en follows tick"});
    st.push_back('{B_0, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "sec_en low no tick"});
    st.push_back('{B_D, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "btn_d idle run"});
    st.push_back('{B_R | B_L, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "r/l ignored in run"});
    foreach (st[i]) begin
      sb.push_back('{st[i].v, st[i].name});
      drive(st[i].b, st[i].tk, st[i].tm);
      e = sb.pop_front();
      checks++;
      if (outs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
      end
    end
  endtask

  task automatic test_set_nav();
    step_t st[$];
    exp_t  e;
    st.push_back('{B_C, 1'b0, T_OFF, mk(3'd1, A_NO, 5'b00100), "enter clk hr"});
    st.push_back('{B_R, 1'b0, T_OFF, mk(3'd2, A_NO, 5'b00100), "right to clk min"});
    st.push_back('{B_R, 1'b0, T_OFF, mk(3'd3, A_NO, 5'b01100), "right to alm hr"});
    st.push_back('{B_U, 1'b1, T_OFF, mk(3'd3, A_AHU, 5'b01000), "alm hr up frozen sec"});
    st.push_back('{B_0, 1'b1, T_OFF, mk(3'd3, A_NO, 5'b01100), "single pulse, blink"});
    st.push_back('{B_0, 1'b0, T_OFF, mk(3'd3, A_NO, 5'b01100), "hold alm hr"});
    st.push_back('{B_C, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "centre back to run"});
    st.push_back('{B_C, 1'b0, T_OFF, mk(3'd1, A_NO, 5'b00100), "re-enter clk hr"});
    st.push_back('{B_L, 1'b0, T_OFF, mk(3'd4, A_NO, 5'b01100), "left wraps to alm min"});
    st.push_back('{B_R, 1'b0, T_OFF, mk(3'd1, A_NO, 5'b00100), "right wraps to clk hr"});
    st.push_back('{B_C | B_U, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "c beats u no pulse"});
    st.push_back('{B_0, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "no late pulse"});
    foreach (st[i]) begin
      sb.push_back('{st[i].v, st[i].name});
      drive(st[i].b, st[i].tk, st[i].tm);
      e = sb.pop_front();
      checks++;
      if (outs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
      end
    end
  endtask

  task automatic test_adjust_fields();
    step_t st[$];
    exp_t  e;
    st.push_back('{B_C, 1'b0, T_OFF, mk(3'd1, A_NO, 5'b00100), "enter clk hr"});
    st.push_back('{B_U, 1'b0, T_OFF, mk(3'd1, A_CHU, 5'b00100), "clk hr up"});
    st.push_back('{B_D, 1'b1, T_OFF, mk(3'd1, A_CHD, 5'b00000), "clk hr dn blink off"});
    st.push_back('{B_R, 1'b0, T_OFF, mk(3'd2, A_NO, 5'b00100), "clk min entry blink on"});
    st.push_back('{B_U, 1'b0, T_OFF, mk(3'd2, A_CMU, 5'b00100), "clk min up"});
    st.push_back('{B_D, 1'b0, T_OFF, mk(3'd2, A_CMD, 5'b00100), "clk min dn"});
    st.push_back('{B_R, 1'b0, T_OFF, mk(3'd3, A_NO, 5'b01100), "to alm hr"});
    st.push_back('{B_D, 1'b0, T_OFF, mk(3'd3, A_AHD, 5'b01100), "alm hr dn"});
    st.push_back('{B_R, 1'b0, T_OFF, mk(3'd4, A_NO, 5'b01100), "to alm min"});
    st.push_back('{B_U | B_D, 1'b0, T_OFF, mk(3'd4, A_AMU, 5'b01100), "u beats d"});
    st.push_back('{B_D, 1'b0, T_OFF, mk(3'd4, A_AMD, 5'b01100), "alm min dn"});
    st.push_back('{B_R, 1'b0, T_OFF, mk(3'd1, A_NO, 5'b00100), "right wrap"});
    st.push_back('{B_L, 1'b0, T_OFF, mk(3'd4, A_NO, 5'b01100), "left wrap"});
    st.push_back('{B_R | B_U, 1'b0, T_OFF, mk(3'd1, A_NO, 5'b00100), "r beats u"});
    st.push_back('{B_L | B_U | B_D, 1'b0, T_OFF, mk(3'd4, A_NO, 5'b01100), "l beats u,d"});
    st.push_back('{B_C | B_R, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "c beats r"});
    foreach (st[i]) begin
      sb.push_back('{st[i].v, st[i].name});
      drive(st[i].b, st[i].tk, st[i].tm);
      e = sb.pop_front();
      checks++;
      if (outs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
      end
    end
  endtask

  task automatic test_reset_mid_set();
    step_t st[$];
    exp_t  e;
    st.push_back('{B_U, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00010), "arm before reset"});
    st.push_back('{B_C, 1'b0, T_OFF, mk(3'd1, A_NO, 5'b00110), "enter clk hr"});
    st.push_back('{B_L, 1'b0, T_OFF, mk(3'd4, A_NO, 5'b01110), "to alm min"});
    foreach (st[i]) begin
      sb.push_back('{st[i].v, st[i].name});
      drive(st[i].b, st[i].tk, st[i].tm);
      e = sb.pop_front();
      checks++;
      if (outs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
      end
    end
    @(negedge clk);
    btn_u = 1'b1;
    reset = 1'b1;
    sb.push_back('{mk(3'd0, A_NO, 5'b00000), "async reset immediate"});
    #1;
    e = sb.pop_front();
    checks++;
    if (outs !== e.v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
    end
    sb.push_back('{mk(3'd0, A_NO, 5'b00000), "no alm min pulse in reset"});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (outs !== e.v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
    end
    @(negedge clk);
    reset = 1'b0;
    btn_u = 1'b0;
    btn_c = 1'b1;
    sb.push_back('{mk(3'd1, A_NO, 5'b00100), "first edge after release"});
    @(posedge clk);
    #1;
    btn_c = 1'b0;
    e = sb.pop_front();
    checks++;
    if (outs !== e.v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
    end
    sb.push_back('{mk(3'd0, A_NO, 5'b00000), "back to run"});
    drive(B_C, 1'b0, T_OFF);
    e = sb.pop_front();
    checks++;
    if (outs !== e.v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
    end
  endtask

  task automatic test_alarm();
    step_t st[$];
    exp_t  e;
    st.push_back('{B_U, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00010), "arm"});
    st.push_back('{B_0, 1'b0, T_MATCH, mk(3'd0, A_NO, 5'b00011), "trigger on match"});
    for (int i = 0; i < 59; i++)
      st.push_back('{B_0, 1'b1, T_MATCH, mk(3'd0, A_NO, 5'b10011), "ringing before timeout"});
    st.push_back('{B_0, 1'b1, T_MATCH, mk(3'd0, A_NO, 5'b10010), "timeout at 60 ticks"});
    for (int i = 0; i < 3; i++)
      st.push_back('{B_0, 1'b0, T_MATCH, mk(3'd0, A_NO, 5'b00010), "held match no retrigger"});
    st.push_back('{B_0, 1'b0, T_NEAR, mk(3'd0, A_NO, 5'b00010), "match drops"});
    st.push_back('{B_0, 1'b0, T_MATCH, mk(3'd0, A_NO, 5'b00011), "retrigger"});
    st.push_back('{B_C, 1'b0, T_MATCH, mk(3'd0, A_NO, 5'b00010), "centre clears stays run"});
    st.push_back('{B_0, 1'b0, T_MATCH, mk(3'd0, A_NO, 5'b00010), "no retrigger after clear"});
    st.push_back('{B_0, 1'b0, T_NEAR, mk(3'd0, A_NO, 5'b00010), "match drops again"});
    st.push_back('{B_0, 1'b0, T_MATCH, mk(3'd0, A_NO, 5'b00011), "ring again"});
    st.push_back('{B_U, 1'b0, T_MATCH, mk(3'd0, A_NO, 5'b00000), "disarm clears ring"});
    st.push_back('{B_0, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "quiet disarmed"});
    foreach (st[i]) begin
      sb.push_back('{st[i].v, st[i].name});
      drive(st[i].b, st[i].tk, st[i].tm);
      e = sb.pop_front();
      checks++;
      if (outs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
      end
    end
  endtask

  task automatic test_snooze();
    step_t st[$];
    exp_t  e;
    st.push_back('{B_U, 1'b0, T_NEAR, mk(3'd0, A_NO, 5'b00010), "arm"});
    st.push_back('{B_0, 1'b0, T_MATCH, mk(3'd0, A_NO, 5'b00011), "ring"});
`ifdef ALARM_SNOOZE_EN
    st.push_back('{B_D, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00010), "snooze silences"});
    st.push_back('{B_0, 1'b1, T_OFF, mk(3'd0, A_NO, 5'b10010), "snooze tick 1"});
    st.push_back('{B_0, 1'b1, T_OFF, mk(3'd0, A_NO, 5'b10010), "snooze tick 2"});
    st.push_back('{B_0, 1'b1, T_OFF, mk(3'd0, A_NO, 5'b10011), "snooze expires"});
    st.push_back('{B_C, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00010), "clear after snooze"});
    st.push_back('{B_0, 1'b0, T_MATCH, mk(3'd0, A_NO, 5'b00011), "ring for cancel"});
    st.push_back('{B_D, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00010), "snooze again"});
    st.push_back('{B_U, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "disarm in snooze"});
    st.push_back('{B_U, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00010), "rearm"});
    for (int i = 0; i < 4; i++)
      st.push_back('{B_0, 1'b1, T_OFF, mk(3'd0, A_NO, 5'b10010), "snooze cancelled"});
`else
    st.push_back('{B_D, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00011), "btn_d ignored ringing"});
    for (int i = 0; i < 3; i++)
      st.push_back('{B_0, 1'b1, T_OFF, mk(3'd0, A_NO, 5'b10011), "still ringing"});
    st.push_back('{B_C, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00010), "centre clears"});
`endif
    st.push_back('{B_U, 1'b0, T_OFF, mk(3'd0, A_NO, 5'b00000), "final disarm"});
    foreach (st[i]) begin
      sb.push_back('{st[i].v, st[i].name});
      drive(st[i].b, st[i].tk, st[i].tm);
      e = sb.pop_front();
      checks++;
      if (outs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, outs, e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_set_nav();
    test_adjust_fields();
    test_reset_mid_set();
    test_alarm();
    test_snooze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/clock_mode_controller.md
CLOCK_MODE_CONTROLLER -- requirements
Module: clock_mode_controller

Interface
REQ-001 SHALL have parameter ALARM_TIMEOUT, default 60, seconds an alarm rings before auto-clear (1..255).
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, snooze length in seconds (1..1023); used only with ALARM_SNOOZE_EN.
REQ-003 SHALL have port clk  input  1  system clock, all state updated on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports btn_c, btn_u, btn_d, btn_l, btn_r  input  1 each  debounced single-cycle button pulses.
REQ-006 SHALL have port tick_1hz  input  1  one-cycle pulse once per second.
REQ-007 SHALL have ports clk_hr (5), clk_min (6), clk_sec (6), alm_hr (5), alm_min (6)  input  current counter values.
REQ-008 SHALL have port sec_en  output  1  enable to the seconds counter.
REQ-009 SHALL have ports clk_hr_up, clk_hr_dn, clk_min_up, clk_min_dn, alm_hr_up, alm_hr_dn, alm_min_up, alm_min_dn  output  1 each  single-cycle adjust pulses to the hour/minute counters.
REQ-010 SHALL have ports mode  output  3  current state encoding; show_alarm  output  1  display alarm time; blink  output  1  blink of field being set.
REQ-011 SHALL have ports alarm_armed  output  1  and alarm_active  output  1  (buzzer drive).

Function
REQ-012 States SHALL be RUN=0, SET_CLK_HR=1, SET_CLK_MIN=2, SET_ALM_HR=3, SET_ALM_MIN=4; codes 5-7 SHALL go to RUN next cycle.
REQ-013 Button priority within a cycle SHALL be c > r > l > u > d; only the highest-priority asserted button acts.
REQ-014 RUN: btn_c with alarm_active=0 -> SET_CLK_HR; btn_c with alarm_active=1 clears alarm, stays RUN; btn_u toggles alarm_armed.
REQ-015 Set states: btn_c -> RUN; btn_r advances CLK_HR->CLK_MIN->ALM_HR->ALM_MIN->CLK_HR; btn_l moves in reverse order with the same wrap.
REQ-016 Set states: btn_u/btn_d SHALL produce exactly one up/down pulse on the selected field's output, registered, asserted the cycle after the button.
REQ-017 All adjust outputs SHALL be 0 in RUN; at most one adjust output SHALL be high in any cycle.
REQ-018 sec_en SHALL equal tick_1hz registered (one-cycle latency) in RUN, and 0 in every set state (clock frozen while setting).
REQ-019 blink SHALL be 0 in RUN, be 1 on entry to any set state, and toggle on each tick_1hz while in a set state.
REQ-020 show_alarm SHALL be 1 in SET_ALM_HR/SET_ALM_MIN, else 0.
REQ-021 Alarm SHALL trigger (alarm_active 0->1) on the first cycle with state RUN, alarm_armed=1, clk_hr==alm_hr, clk_min==alm_min, clk_sec==0; it SHALL NOT retrigger until the match condition has gone false.
REQ-022 An 8-bit ring counter SHALL count tick_1hz while alarm_active; reaching ALARM_TIMEOUT clears alarm_active.
REQ-023 Disarming (btn_u in RUN) SHALL clear alarm_active in the same update.
REQ-024 Leaving RUN (impossible while ringing per REQ-014) SHALL never leave adjust pulses pending.

Reset
REQ-025 On reset: state RUN, mode=0, all outputs 0, alarm_armed=0, alarm_active=0, ring and snooze counters 0; effective immediately, regardless of state or pending button.
REQ-026 Reset deassertion SHALL require no extra cycles; first rising edge after release is a normal cycle.

Configuration
REQ-027 Macro ALARM_SNOOZE_EN SHALL gate the snooze feature.
REQ-028 Defined: btn_d in RUN with alarm_active=1 clears alarm_active and loads a 10-bit snooze counter with SNOOZE_SEC; it decrements per tick_1hz and at 0 sets alarm_active (if still armed), independent of REQ-021 match; disarming cancels snooze.
REQ-029 Not defined: btn_d in RUN SHALL be ignored; no snooze counter exists.

Verification
REQ-030 Reset mid SET_ALM_MIN with btn_u pending -> mode=0, no alm_min_up pulse, all outputs 0.
REQ-031 RUN, btn_c, btn_r x2, btn_u -> mode=3, alm_hr_up high exactly one cycle, sec_en held 0 despite tick_1hz.
REQ-032 SET_CLK_HR, btn_l -> mode=4; btn_r -> mode=1; btn_c+btn_u same cycle -> mode=0, no adjust pulse.
REQ-033 Armed, alm 07:30, inputs clk 07:30:00 -> alarm_active=1; 60 ticks later -> 0; held match does not retrigger.
REQ-034 ALARM_SNOOZE_EN, SNOOZE_SEC=3: ringing, btn_d -> alarm_active=0; after 3 ticks -> 1; without macro btn_d -> still ringing.
